mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. One shared memory serves both instruction and data, and one ALU is reused across cycles. The block decodes the instruction-register opcode/funct fields and sequences the datapath through fetch, decode, execute, memory and writeback states. It emits all mux selects and write enables, including the gated PC enable.

---
 rtl/mips_multicycle_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: decodes op/funct and
// sequences fetch/decode/execute/memory/writeback with Moore-decoded controls.
module mips_multicycle_ctrl #(
    parameter bit SUPPORT_BNE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMRD    = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWR    = 4'd5;
    localparam logic [3:0] EXECUTE  = 4'd6;
    localparam logic [3:0] ALUWB    = 4'd7;
    localparam logic [3:0] BRANCH   = 4'd8;
    localparam logic [3:0] ADDIEXEC = 4'd9;
    localparam logic [3:0] ADDIWB   = 4'd10;
    localparam logic [3:0] JUMP     = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic [3:0] state_next;
    logic       pcwrite;
    logic       branch;
    logic       taken;
    logic       funct_ok;
    logic [2:0] funct_alu;

    // State register; reset aborts any in-flight instruction.
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // R-type function decode.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    assign taken = (SUPPORT_BNE && (op == OP_BNE)) ? ~zero : zero;

    // Next-state and Moore output decode; write enables masked while in reset.
    always_comb begin
        state_next = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        case (state)
            FETCH: begin
                irwrite    = 1'b1;
                pcwrite    = 1'b1;
                alusrcb    = 2'b01;
                state_next = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_RTYPE:     state_next = funct_ok ? EXECUTE : FETCH;
                    OP_BEQ:       state_next = BRANCH;
                    OP_BNE:       state_next = SUPPORT_BNE ? BRANCH : FETCH;
                    OP_ADDI:      state_next = ADDIEXEC;
                    OP_J:         state_next = JUMP;
                    default:      state_next = FETCH;
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord       = 1'b1;
                state_next = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu;
                state_next = ALUWB;
            end
            ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                branch     = 1'b1;
            end
            ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                state_next = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_next = FETCH;
        endcase
        pcen = (pcwrite | (branch & taken)) & ~reset;
        if (reset) begin
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl; a second instance with bne disabled
// runs in lockstep on the same inputs.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;

    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    logic       n_pcen, n_iord, n_memwrite, n_irwrite, n_regdst, n_memtoreg, n_regwrite, n_alusrca;
    logic [1:0] n_alusrcb, n_pcsrc;
    logic [2:0] n_alucontrol;
    logic [3:0] n_state;

    int checks = 0;
    int errors = 0;

    mips_multicycle_ctrl #(.SUPPORT_BNE(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .state(state)
    );

    mips_multicycle_ctrl #(.SUPPORT_BNE(1'b0)) dut_nobne (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(n_pcen), .iord(n_iord), .memwrite(n_memwrite), .irwrite(n_irwrite),
        .regdst(n_regdst), .memtoreg(n_memtoreg), .regwrite(n_regwrite),
        .alusrca(n_alusrca), .alusrcb(n_alusrcb), .pcsrc(n_pcsrc),
        .alucontrol(n_alucontrol), .state(n_state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'b000000;
        funct = 6'b100000;
        zero  = 1'b0;
        #1;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pcen", 32'(pcen), 32'd0);
        chk("rst_irwrite", 32'(irwrite), 32'd0);

        // Fetch outputs after reset release, then drive an add R-type to ALUWB.
        reset = 1'b0;
        #1;
        chk("fetch_irwrite", 32'(irwrite), 32'd1);
        chk("fetch_pcen", 32'(pcen), 32'd1);
        chk("fetch_alusrcb", 32'(alusrcb), 32'd1);
        chk("fetch_aluctl", 32'(alucontrol), 32'd2);
        step();
        chk("add_decode", 32'(state), 32'd1);
        chk("decode_alusrcb", 32'(alusrcb), 32'd3);
        step();
        chk("add_exec", 32'(state), 32'd6);
        step();
        chk("add_aluwb", 32'(state), 32'd7);
        chk("add_aluwb_rw", 32'(regwrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_aluwb_state", 32'(state), 32'd7);
        chk("rst_aluwb_rw", 32'(regwrite), 32'd0);
        step();
        chk("rst_edge1_state", 32'(state), 32'd0);
        chk("rst_edge1_rw", 32'(regwrite), 32'd0);
        step();
        chk("rst_edge2_state", 32'(state), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_irwrite", 32'(irwrite), 32'd1);
        chk("post_rst_pcen", 32'(pcen), 32'd1);

        // lw: 0,1,2,3,4,0
        op = 6'b100011;
        chk("lw_s0_mw", 32'(memwrite), 32'd0);
        chk("lw_s0_iord", 32'(iord), 32'd0);
        step();
        chk("lw_s1", 32'(state), 32'd1);
        chk("lw_s1_mw", 32'(memwrite), 32'd0);
        step();
        chk("lw_s2", 32'(state), 32'd2);
        chk("lw_s2_alusrca", 32'(alusrca), 32'd1);
        chk("lw_s2_alusrcb", 32'(alusrcb), 32'd2);
        chk("lw_s2_iord", 32'(iord), 32'd0);
        step();
        chk("lw_s3", 32'(state), 32'd3);
        chk("lw_s3_iord", 32'(iord), 32'd1);
        chk("lw_s3_rw", 32'(regwrite), 32'd0);
        chk("lw_s3_mw", 32'(memwrite), 32'd0);
        step();
        chk("lw_s4", 32'(state), 32'd4);
        chk("lw_s4_rw", 32'(regwrite), 32'd1);
        chk("lw_s4_mtr", 32'(memtoreg), 32'd1);
        chk("lw_s4_regdst", 32'(regdst), 32'd0);
        chk("lw_s4_iord", 32'(iord), 32'd0);
        chk("lw_s4_mw", 32'(memwrite), 32'd0);
        step();
        chk("lw_end", 32'(state), 32'd0);

        // slt then or
        op    = 6'b000000;
        funct = 6'b101010;
        step();
        chk("slt_s1", 32'(state), 32'd1);
        step();
        chk("slt_s6", 32'(state), 32'd6);
        chk("slt_aluctl", 32'(alucontrol), 32'd7);
        chk("slt_alusrca", 32'(alusrca), 32'd1);
        chk("slt_alusrcb", 32'(alusrcb), 32'd0);
        step();
        chk("slt_s7", 32'(state), 32'd7);
        chk("slt_regdst", 32'(regdst), 32'd1);
        chk("slt_rw", 32'(regwrite), 32'd1);
        step();
        chk("slt_end", 32'(state), 32'd0);
        funct = 6'b100101;
        step();
        step();
        chk("or_s6", 32'(state), 32'd6);
        chk("or_aluctl", 32'(alucontrol), 32'd1);
        step();
        step();
        chk("or_end", 32'(state), 32'd0);

        // Unsupported funct retires as a 2-cycle nop.
        funct = 6'b000000;
        step();
        chk("badfn_s1", 32'(state), 32'd1);
        step();
        chk("badfn_end", 32'(state), 32'd0);

        // beq taken / not taken
        op   = 6'b000100;
        zero = 1'b1;
        step();
        step();
        chk("beq_s8", 32'(state), 32'd8);
        chk("beq_t_pcen", 32'(pcen), 32'd1);
        chk("beq_pcsrc", 32'(pcsrc), 32'd1);
        chk("beq_aluctl", 32'(alucontrol), 32'd6);
        zero = 1'b0;
        #1;
        chk("beq_nt_pcen", 32'(pcen), 32'd0);
        step();
        chk("beq_end", 32'(state), 32'd0);

        // bne: taken on zero=0; disabled instance retires it as nop.
        op = 6'b000101;
        step();
        chk("bne_s1", 32'(state), 32'd1);
        chk("nobne_s1_pcen", 32'(n_pcen), 32'd0);
        step();
        chk("bne_s8", 32'(state), 32'd8);
        chk("bne_t_pcen", 32'(pcen), 32'd1);
        chk("nobne_back", 32'(n_state), 32'd0);
        zero = 1'b1;
        #1;
        chk("bne_nt_pcen", 32'(pcen), 32'd0);
        zero = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        chk("resync", 32'(state), 32'd0);
        chk("resync_nobne", 32'(n_state), 32'd0);

        // j
        op = 6'b000010;
        step();
        step();
        chk("j_s11", 32'(state), 32'd11);
        chk("j_pcsrc", 32'(pcsrc), 32'd2);
        chk("j_pcen", 32'(pcen), 32'd1);
        step();
        chk("j_end", 32'(state), 32'd0);

        // unsupported op
        op = 6'b111111;
        step();
        chk("bad_s1", 32'(state), 32'd1);
        chk("bad_s1_mw", 32'(memwrite), 32'd0);
        chk("bad_s1_rw", 32'(regwrite), 32'd0);
        step();
        chk("bad_end", 32'(state), 32'd0);

        // sw aborted by reset in MEMADR
        op = 6'b101011;
        step();
        step();
        chk("sw_s2", 32'(state), 32'd2);
        reset = 1'b1;
        #1;
        chk("sw_rst_mw", 32'(memwrite), 32'd0);
        step();
        chk("sw_abort", 32'(state), 32'd0);
        chk("sw_abort_mw", 32'(memwrite), 32'd0);
        reset = 1'b0;

        // addi
        op = 6'b001000;
        #1;
        step();
        chk("addi_s1", 32'(state), 32'd1);
        step();
        chk("addi_s9", 32'(state), 32'd9);
        chk("addi_alusrcb", 32'(alusrcb), 32'd2);
        chk("addi_alusrca", 32'(alusrca), 32'd1);
        step();
        chk("addi_s10", 32'(state), 32'd10);
        chk("addi_rw", 32'(regwrite), 32'd1);
        chk("addi_regdst", 32'(regdst), 32'd0);
        chk("addi_mtr", 32'(memtoreg), 32'd0);
        step();
        chk("addi_end", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
